tc_timer: RTL and testbench
===========================

TC_TIMER -- requirements
Module: tc_timer

Interface
Parameters (name, default, meaning):
REQ-001 BASE_ADDR, 32'h0000_7F00, word-aligned base of the 16-byte register window; only bits [31:4] are compared.
Ports (name  direction  width  meaning):
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 addr  input  32  byte address from the CPU data port.
REQ-005 we  input  1  write strobe, sampled on the rising edge of clk.
REQ-006 din  input  32  write data.
REQ-007 byteen  input  4  per-byte write enable; present only when TC_BYTEEN_EN is defined (see Configuration).
REQ-008 dout  output  32  read data, combinational from addr.
REQ-009 irq  output  1  interrupt request to the CPU interrupt input.

Function
REQ-010 Hit = (addr[31:4] == BASE_ADDR[31:4]); select = addr[3:2]: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
REQ-011 dout SHALL return the selected register on a hit, reads 0 for reserved or miss, with no side effects.
REQ-012 CTRL bits: [0] EN, [2:1] MODE, [3] IM (interrupt mask); bits [31:4] read 0, writes ignored.
REQ-013 Writes apply only on hit & we; COUNT and reserved are read-only, writes ignored.
REQ-014 States: IDLE, LOAD, CNT, INT; registered, 2-bit encoding.
REQ-015 IDLE: EN=1 -> LOAD, else stay.
REQ-016 LOAD: COUNT <= PRESET; -> CNT.
REQ-017 CNT: EN=0 -> IDLE, COUNT frozen; else COUNT==0 -> INT with irq_flag <= 1; else COUNT <= COUNT-1.
REQ-018 INT, MODE==1 (auto-reload): -> LOAD, irq_flag <= 0, so the flag is high exactly one cycle per period.
REQ-019 INT, MODE!=1 (one-shot; MODE 0/2/3 identical): CTRL.EN <= 0, -> IDLE, irq_flag held until any bus write to CTRL.
REQ-020 irq = irq_flag & CTRL.IM; combinational, glitch-free from registers only.
REQ-021 Latency: CTRL write with EN=1 at edge E0 -> irq_flag visible after edge E0+PRESET+3; auto-reload period = PRESET+3 cycles.
REQ-022 PRESET=0 is legal: LOAD, CNT (count 0), INT -- no underflow, COUNT never wraps past 0.
REQ-023 PRESET write during CNT SHALL NOT affect COUNT until the next LOAD.
REQ-024 Simultaneous bus write to CTRL and INT-state EN clear in the same edge: bus write wins, irq_flag cleared.
REQ-025 CTRL write with EN=0 during CNT: next edge IDLE; COUNT retains value; re-enable reloads PRESET.

Reset
REQ-026 On reset: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq_flag=0; therefore irq=0 and dout=0 for every address.
REQ-027 Reset SHALL override any simultaneous bus write and abort counting mid-operation with no irq pulse.

Configuration
REQ-028 Macro TC_BYTEEN_EN: when defined, byteen port exists and each written register merges only bytes with byteen[i]=1; byteen=0 with we=1 changes nothing (CTRL irq_flag clear also requires byteen[0]=1).
REQ-029 When TC_BYTEEN_EN is undefined, port byteen is absent and every qualifying write replaces the full 32-bit word.

Verification
REQ-030 Reset, then read offsets 0x0/0x4/0x8/0xC -> all dout=0, irq=0.
REQ-031 PRESET=3, CTRL=0x9 (EN, one-shot, IM) at E0 -> COUNT reads 3,2,1,0; irq rises after E6 and stays high; CTRL reads 0x8; write CTRL=0x8 -> irq low next cycle.
REQ-032 PRESET=2, CTRL=0xB (auto-reload) -> irq high one cycle every 5 cycles, at least 3 periods.
REQ-033 CTRL=0x1 (IM=0) one-shot, PRESET=1 -> irq stays 0; later CTRL=0x8 write observed: irq stays 0 (flag cleared by write).
REQ-034 Mid-count (COUNT=5) write CTRL=0x0 -> COUNT frozen at 4 or 5 per REQ-017 timing, state IDLE; write 0x9 -> COUNT reloads PRESET; assert reset mid-count -> all registers 0, no irq.
REQ-035 With TC_BYTEEN_EN: write PRESET=0xAABBCCDD byteen=4'b0011 over 0 -> PRESET reads 0x0000CCDD; write to COUNT (0x8) -> value unchanged.

Source files
------------

// File: rtl/tc_timer.sv
// Memory-mapped down-counter timer with CTRL/PRESET/COUNT registers and a maskable interrupt.
// Optional per-byte write enables are compiled in when TC_BYTEEN_EN is defined.
module tc_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
`ifdef TC_BYTEEN_EN
    input  logic [3:0]  byteen,
`endif
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic        hit;
    logic [1:0]  sel;
    logic [3:0]  be;
    logic [31:0] wmask;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        ctrl_en;
    logic        auto_reload;
    logic [1:0]  unused_addr_bits;

    assign hit              = (addr[31:4] == BASE_ADDR[31:4]);
    assign sel              = addr[3:2];
    assign unused_addr_bits = addr[1:0];

`ifdef TC_BYTEEN_EN
    assign be = byteen;
`else
    assign be = '1;
`endif

    assign wmask       = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    // CTRL only implements byte 0, so a write that does not enable it is a no-op
    assign ctrl_wr     = hit & we & (sel == 2'd0) & be[0];
    assign preset_wr   = hit & we & (sel == 2'd1);
    assign ctrl_en     = ctrl_q[0];
    assign auto_reload = (ctrl_q[2:1] == 2'b01);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_en) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    state_d = ST_INT;
                    flag_d  = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                if (auto_reload) begin
                    state_d = ST_LOAD;
                    flag_d  = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus writes are applied last so they take priority over the FSM's own updates
        if (ctrl_wr) begin
            ctrl_d = din[3:0];
            flag_d = 1'b0;
        end
        if (preset_wr) begin
            preset_d = (preset_q & ~wmask) | (din & wmask);
        end
    end

    always_comb begin
        dout = '0;
        if (hit) begin
            case (sel)
                2'd0:    dout = {28'd0, ctrl_q};
                2'd1:    dout = preset_q;
                2'd2:    dout = count_q;
                default: dout = '0;
            endcase
        end
    end

    assign irq = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_tc_timer.sv
// Directed self-checking bench for tc_timer: reset, one-shot, auto-reload, masking,
// zero preset, mid-count disable/reset, read-only registers and optional byte enables.
module tb_tc_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
`ifdef TC_BYTEEN_EN
    logic [3:0]  byteen;
`endif
    logic [31:0] dout;
    logic        irq;

    int unsigned n_checks;
    int unsigned n_fail;

    tc_timer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
`ifdef TC_BYTEEN_EN
        .byteen(byteen),
`endif
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b1;
        addr  = A_PRE;
        din   = 32'hFFFF_FFFF;
        we    = 1'b1;
        step(2);
        we    = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            peek(BASE + 32'(i * 4), v);
            n_checks++;
            if (v !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h expected %h", i, v, 32'h0);
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        wr(A_PRE, 32'd3);
        peek(A_PRE, v);
        n_checks++;
        if (v !== 32'd3) begin n_fail++; $display("FAIL preset_read: got %h expected %h", v, 32'd3); end
        peek(32'h0000_8F04, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL miss_read: got %h expected 0", v); end
        wr(A_CTRL, 32'h9);
        step(1);
        addr = A_CNT;
        for (int k = 2; k <= 5; k++) begin
            step(1);
            n_checks++;
            if (dout !== 32'(5 - k)) begin
                n_fail++;
                $display("FAIL oneshot_count_E%0d: got %h expected %h", k, dout, 32'(5 - k));
            end
            n_checks++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_early_E%0d: got %b expected 0", k, irq); end
        end
        step(1);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_E6: got %b expected 1", irq); end
        step(3);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_held: got %b expected 1", irq); end
        peek(A_CTRL, v);
        n_checks++;
        if (v !== 32'h8) begin n_fail++; $display("FAIL oneshot_ctrl_en_cleared: got %h expected %h", v, 32'h8); end
        wr(A_CTRL, 32'h8);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_cleared: got %b expected 0", irq); end
    endtask

    task automatic test_autoreload;
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            step(1);
            n_checks++;
            if (irq !== (k % 5 == 0)) begin
                n_fail++;
                $display("FAIL autoreload_irq_E%0d: got %b expected %b", k, irq, (k % 5 == 0));
            end
        end
        wr(A_CTRL, 32'h8);
        step(3);
    endtask

    task automatic test_masked;
        logic [31:0] v;
        wr(A_PRE, 32'd1);
        wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            n_checks++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_irq_E%0d: got %b expected 0", k, irq); end
        end
        peek(A_CTRL, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL masked_ctrl_en_cleared: got %h expected 0", v); end
        wr(A_CTRL, 32'h8);
        step(1);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_irq_after_unmask: got %b expected 0", irq); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        wr(A_PRE, 32'd0);
        wr(A_CTRL, 32'h9);
        step(2);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL zero_irq_E2: got %b expected 0", irq); end
        step(1);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL zero_irq_E3: got %b expected 1", irq); end
        peek(A_CNT, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL zero_count: got %h expected 0", v); end
        // this write lands on the same edge as the INT-state EN clear
        wr(A_CTRL, 32'h9);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL collide_irq_cleared: got %b expected 0", irq); end
        peek(A_CTRL, v);
        n_checks++;
        if (v !== 32'h9) begin n_fail++; $display("FAIL collide_ctrl: got %h expected %h", v, 32'h9); end
        step(2);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL collide_rerun_early: got %b expected 0", irq); end
        step(1);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL collide_rerun_irq: got %b expected 1", irq); end
        step(1);
        wr(A_CTRL, 32'h0);
        step(2);
    endtask

    task automatic test_midcount;
        logic [31:0] v;
        wr(A_PRE, 32'd10);
        wr(A_CTRL, 32'h1);
        step(7);
        peek(A_CNT, v);
        n_checks++;
        if (v !== 32'd5) begin n_fail++; $display("FAIL mid_count5: got %h expected %h", v, 32'd5); end
        wr(A_CTRL, 32'h0);
        step(4);
        peek(A_CNT, v);
        n_checks++;
        if (v !== 32'd4) begin n_fail++; $display("FAIL mid_frozen: got %h expected %h", v, 32'd4); end
        wr(A_PRE, 32'd7);
        wr(A_CTRL, 32'h1);
        step(2);
        peek(A_CNT, v);
        n_checks++;
        if (v !== 32'd7) begin n_fail++; $display("FAIL mid_reload: got %h expected %h", v, 32'd7); end
        wr(A_PRE, 32'd20);
        peek(A_CNT, v);
        n_checks++;
        if (v !== 32'd6) begin n_fail++; $display("FAIL preset_during_cnt: got %h expected %h", v, 32'd6); end
        peek(A_PRE, v);
        n_checks++;
        if (v !== 32'd20) begin n_fail++; $display("FAIL preset_during_cnt_read: got %h expected %h", v, 32'd20); end
        step(2);
        reset = 1'b1;
        addr  = A_CTRL;
        din   = 32'h9;
        we    = 1'b1;
        step(1);
        reset = 1'b0;
        we    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            peek(BASE + 32'(i * 4), v);
            n_checks++;
            if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_read[%0d]: got %h expected 0", i, v); end
        end
        for (int k = 1; k <= 6; k++) begin
            step(1);
            n_checks++;
            if (irq !== 1'b0 || dout !== 32'h0) begin
                n_fail++;
                $display("FAIL midreset_idle_E%0d: got irq=%b count=%h expected irq=0 count=0", k, irq, dout);
            end
        end
    endtask

    task automatic test_readonly;
        logic [31:0] v;
        wr(A_PRE, 32'd5);
        wr(A_CNT, 32'h55);
        peek(A_CNT, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL count_readonly: got %h expected 0", v); end
        wr(A_RSV, 32'hFFFF_FFFF);
        peek(A_RSV, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL reserved_read: got %h expected 0", v); end
        wr(A_CTRL, 32'hFFFF_FFF0);
        peek(A_CTRL, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL ctrl_upper_ignored: got %h expected 0", v); end
        wr(32'h0000_8F04, 32'h77);
        peek(A_PRE, v);
        n_checks++;
        if (v !== 32'd5) begin n_fail++; $display("FAIL miss_write_ignored: got %h expected %h", v, 32'd5); end
    endtask

`ifdef TC_BYTEEN_EN
    task automatic test_byteen;
        logic [31:0] v;
        wr(A_PRE, 32'h0);
        byteen = 4'b0011;
        wr(A_PRE, 32'hAABB_CCDD);
        byteen = 4'b1111;
        peek(A_PRE, v);
        n_checks++;
        if (v !== 32'h0000_CCDD) begin n_fail++; $display("FAIL byteen_merge: got %h expected %h", v, 32'h0000_CCDD); end
        byteen = 4'b0000;
        wr(A_CTRL, 32'h9);
        byteen = 4'b1111;
        peek(A_CTRL, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL byteen_zero: got %h expected 0", v); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        we       = 1'b0;
        addr     = '0;
        din      = '0;
`ifdef TC_BYTEEN_EN
        byteen   = 4'b1111;
`endif
        test_reset();
        test_oneshot();
        test_autoreload();
        test_masked();
        test_back_to_back();
        test_midcount();
        test_readonly();
`ifdef TC_BYTEEN_EN
        test_byteen();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
